// File: rtl/out_xor_reduce_pkg.sv
// Shared definitions for the output XOR reduction stage: mode and FSM encodings
// plus elaboration-time helpers for sizing the reduction tree.
package out_xor_reduce_pkg;

  localparam logic MODE_STREAM = 1'b0;
  localparam logic MODE_SIG    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Nodes present at tree level l when starting from n leaves.
  function automatic int level_nodes(input int n, input int l);
    return (n + (1 << l) - 1) >> l;
  endfunction

  // Flat index of the first node of tree level l (levels numbered from 1).
  function automatic int tree_off(input int n, input int l);
    int r;
    r = 0;
    for (int k = 1; k < l; k++) r = r + level_nodes(n, k);
    return r;
  endfunction

endpackage

// File: rtl/out_xor_reduce_node.sv
// One registered node of the reduction tree: merges two {valid, tag, data}
// operands, dropping the data of whichever side is not valid.
module out_reduce_node #(
  parameter int FOLD_WIDTH = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  a_vld,
  input  logic                  a_tag,
  input  logic [FOLD_WIDTH-1:0] a_dat,
  input  logic                  b_vld,
  input  logic                  b_tag,
  input  logic [FOLD_WIDTH-1:0] b_dat,
  output logic                  y_vld,
  output logic                  y_tag,
  output logic [FOLD_WIDTH-1:0] y_dat
);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      y_vld <= 1'b0;
      y_tag <= 1'b0;
      y_dat <= '0;
    end else begin
      y_vld <= a_vld | b_vld;
      y_tag <= a_tag | b_tag;
      y_dat <= (a_vld ? a_dat : '0) ^ (b_vld ? b_dat : '0);
    end
  end

endmodule

// File: rtl/out_xor_reduce.sv
// Folds NUM_CH kernel output streams, XOR-reduces them through a registered
// pairwise tree onto the pin bus, and builds a per-run signature and word count.
module out_xor_reduce
  import out_xor_reduce_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DIN_WIDTH  = 32,
  parameter int FOLD_WIDTH = 8,
  parameter int OUT_WIDTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        ap_start,
  input  logic                        ap_done,
  input  logic                        mode,
  input  logic [NUM_CH*DIN_WIDTH-1:0] ch_din,
  input  logic [NUM_CH-1:0]           ch_write,
  output logic [NUM_CH-1:0]           ch_full_n,
  output logic [OUT_WIDTH-1:0]        data_out,
  output logic                        data_valid,
  output logic [FOLD_WIDTH-1:0]       sig_out,
  output logic                        sig_valid,
  output logic [CNT_WIDTH-1:0]        word_cnt
);

  localparam int D          = clog2(NUM_CH);
  localparam int DIN_SLICES = DIN_WIDTH / FOLD_WIDTH;
  localparam int OUT_SLICES = FOLD_WIDTH / OUT_WIDTH;
  localparam int PC_W       = clog2(NUM_CH + 1);
  localparam int DRN_W      = clog2(D + 2) + 1;

  function automatic logic [FOLD_WIDTH-1:0] fold_din(input logic [DIN_WIDTH-1:0] x);
    logic [FOLD_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < DIN_SLICES; i++) r = r ^ x[i*FOLD_WIDTH +: FOLD_WIDTH];
    return r;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] fold_out(input logic [FOLD_WIDTH-1:0] x);
    logic [OUT_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < OUT_SLICES; i++) r = r ^ x[i*OUT_WIDTH +: OUT_WIDTH];
    return r;
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [NUM_CH-1:0] x);
    logic [PC_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) r = r + PC_W'(x[i]);
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [PC_W-1:0]      b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH + 1 - PC_W){1'b0}}, b};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  state_t               state, state_nxt;
  logic                 in_run, run_clr, drn_load, report;
  logic [DRN_W-1:0]     drn_cnt;
  logic                 full_n_q;
  logic [FOLD_WIDTH-1:0] sig_acc;
  logic [CNT_WIDTH-1:0] cnt;

  logic                  s1_vld [NUM_CH];
  logic                  s1_tag [NUM_CH];
  logic [FOLD_WIDTH-1:0] s1_dat [NUM_CH];

  logic                  root_vld, root_tag;
  logic [FOLD_WIDTH-1:0] root_dat;

  assign ch_full_n = {NUM_CH{full_n_q}};

  always_ff @(posedge ap_clk) begin
    if (ap_rst) full_n_q <= 1'b0;
    else        full_n_q <= 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_run    = 1'b0;
    run_clr   = 1'b0;
    drn_load  = 1'b0;
    report    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ap_start) begin
          state_nxt = ST_RUN;
          run_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        in_run = 1'b1;
        if (ap_done) begin
          state_nxt = ST_DRAIN;
          drn_load  = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drn_cnt == DRN_W'(1)) state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        report    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The drain counter covers the tree depth so the last tagged word reaches sig_acc.
  always_ff @(posedge ap_clk) begin
    if (ap_rst)                drn_cnt <= '0;
    else if (drn_load)         drn_cnt <= DRN_W'(D + 1);
    else if (state == ST_DRAIN) drn_cnt <= drn_cnt - DRN_W'(1);
  end

  // ---- stage 1: per-channel fold, valid and run tag ----
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        s1_vld[i] <= 1'b0;
        s1_tag[i] <= 1'b0;
        s1_dat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        s1_vld[i] <= ch_write[i];
        s1_tag[i] <= ch_write[i] & in_run;
        s1_dat[i] <= fold_din(ch_din[i*DIN_WIDTH +: DIN_WIDTH]);
      end
    end
  end

  // ---- tree stages: D registered levels of pairwise combine ----
  generate
    if (D == 0) begin : g_no_tree
      assign root_vld = s1_vld[0];
      assign root_tag = s1_tag[0];
      assign root_dat = s1_dat[0];
    end else begin : g_tree
      localparam int TREE_N = tree_off(NUM_CH, D + 1);
      logic                  t_vld [TREE_N];
      logic                  t_tag [TREE_N];
      logic [FOLD_WIDTH-1:0] t_dat [TREE_N];

      for (genvar l = 1; l <= D; l++) begin : g_lvl
        localparam int N    = level_nodes(NUM_CH, l);
        localparam int NP   = level_nodes(NUM_CH, l - 1);
        localparam int OFF  = tree_off(NUM_CH, l);
        localparam int POFF = tree_off(NUM_CH, l - 1);

        for (genvar j = 0; j < N; j++) begin : g_node
          logic                  a_vld, a_tag, b_vld, b_tag;
          logic [FOLD_WIDTH-1:0] a_dat, b_dat;

          if (l == 1) begin : g_src_in
            assign a_vld = s1_vld[2*j];
            assign a_tag = s1_tag[2*j];
            assign a_dat = s1_dat[2*j];
            if (2*j + 1 < NP) begin : g_pair
              assign b_vld = s1_vld[2*j+1];
              assign b_tag = s1_tag[2*j+1];
              assign b_dat = s1_dat[2*j+1];
            end else begin : g_odd
              assign b_vld = 1'b0;
              assign b_tag = 1'b0;
              assign b_dat = '0;
            end
          end else begin : g_src_tree
            assign a_vld = t_vld[POFF+2*j];
            assign a_tag = t_tag[POFF+2*j];
            assign a_dat = t_dat[POFF+2*j];
            if (2*j + 1 < NP) begin : g_pair
              assign b_vld = t_vld[POFF+2*j+1];
              assign b_tag = t_tag[POFF+2*j+1];
              assign b_dat = t_dat[POFF+2*j+1];
            end else begin : g_odd
              assign b_vld = 1'b0;
              assign b_tag = 1'b0;
              assign b_dat = '0;
            end
          end

          out_reduce_node #(.FOLD_WIDTH(FOLD_WIDTH)) u_node (
            .ap_clk (ap_clk),
            .ap_rst (ap_rst),
            .a_vld  (a_vld),
            .a_tag  (a_tag),
            .a_dat  (a_dat),
            .b_vld  (b_vld),
            .b_tag  (b_tag),
            .b_dat  (b_dat),
            .y_vld  (t_vld[OFF+j]),
            .y_tag  (t_tag[OFF+j]),
            .y_dat  (t_dat[OFF+j])
          );
        end
      end

      assign root_vld = t_vld[TREE_N-1];
      assign root_tag = t_tag[TREE_N-1];
      assign root_dat = t_dat[TREE_N-1];
    end
  endgenerate

  // ---- final stage: fold root onto the pin bus ----
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_out   <= fold_out(root_dat);
      data_valid <= root_vld & (mode == MODE_STREAM);
    end
  end

  // ---- signature accumulation and reporting ----
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sig_acc <= '0;
      cnt     <= '0;
    end else if (run_clr) begin
      sig_acc <= '0;
      cnt     <= '0;
    end else begin
      if (root_tag) sig_acc <= sig_acc ^ root_dat;
      cnt <= sat_add(cnt, popcount(ch_write & {NUM_CH{in_run}}));
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sig_out   <= '0;
      word_cnt  <= '0;
      sig_valid <= 1'b0;
    end else begin
      sig_valid <= report & (mode == MODE_SIG);
      if (report) begin
        sig_out  <= sig_acc;
        word_cnt <= cnt;
      end
    end
  end

endmodule
